// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one grant at a time, bounded hold, one dead cycle between owners.
// Define BUS_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module bus_arbiter #(
  parameter int N_SRC    = 32,
  parameter int CODE_W   = 5,
  parameter int MAX_HOLD = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [N_SRC-1:0]  req,
  input  logic              done,
  output logic              grant_valid,
  output logic [N_SRC-1:0]  grant_onehot,
  output logic [CODE_W-1:0] grant_code,
  output logic              busy,
  output logic              timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [1:0]        r_state;
  logic [CODE_W-1:0] r_owner;
  logic [3:0]        r_hold_cnt;
  logic              r_grant_valid;
  logic [N_SRC-1:0]  r_grant_onehot;
  logic [CODE_W-1:0] r_grant_code;
  logic              r_busy;
  logic              r_timeout;

  logic [CODE_W-1:0] w_base;
  logic [CODE_W-1:0] w_idx;
  logic [CODE_W-1:0] w_win;
  logic              w_found;
  logic [1:0]        w_state_nxt;
  logic [CODE_W-1:0] w_owner_nxt;
  logic [3:0]        w_hold_nxt;
  logic              w_take;
  logic              w_timeout_nxt;
  logic              w_valid_nxt;
  logic [N_SRC-1:0]  w_onehot_nxt;

`ifdef BUS_ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [CODE_W-1:0] r_rr_ptr;

  assign w_base = r_rr_ptr;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_rr_ptr <= '0;
    end else if (w_take) begin
      r_rr_ptr <= w_win + CODE_W'(1);
    end
  end
`endif

  // Search upward from w_base, wrapping naturally through the CODE_W-bit index.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_idx = w_base + CODE_W'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_hold_nxt    = r_hold_cnt;
    w_take        = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_take      = 1'b1;
        end
      end
      S_GRANT: begin
        // done outranks expiry, so a coincident done never raises timeout.
        if (done || !req[r_owner]) begin
          w_state_nxt = S_GAP;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt   = S_GAP;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + 4'd1;
        end
      end
      S_GAP: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_take      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_take) begin
      w_owner_nxt = w_win;
      w_hold_nxt  = 4'd0;
    end
  end

  assign w_valid_nxt  = (w_state_nxt == S_GRANT);
  assign w_onehot_nxt = w_valid_nxt ? ({{(N_SRC-1){1'b0}}, 1'b1} << w_owner_nxt) : '0;

  // Outputs are registered from next-state values so the bus sees no req->grant glitch path.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state        <= S_IDLE;
      r_owner        <= '0;
      r_hold_cnt     <= 4'd0;
      r_grant_valid  <= 1'b0;
      r_grant_onehot <= '0;
      r_grant_code   <= '0;
      r_busy         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      r_state        <= w_state_nxt;
      r_owner        <= w_owner_nxt;
      r_hold_cnt     <= w_hold_nxt;
      r_grant_valid  <= w_valid_nxt;
      r_grant_onehot <= w_onehot_nxt;
      r_grant_code   <= w_valid_nxt ? w_owner_nxt : '0;
      r_busy         <= (w_state_nxt != S_IDLE);
      r_timeout      <= w_timeout_nxt;
    end
  end

  assign grant_valid  = r_grant_valid;
  assign grant_onehot = r_grant_onehot;
  assign grant_code   = r_grant_code;
  assign busy         = r_busy;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic against a cycle model.
// Honours BUS_ARB_FIXED_PRIO_EN the same way the design does.
module tb_bus_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int PH_IDLE  = 0;
  localparam int PH_GRANT = 1;
  localparam int PH_GAP   = 2;

  logic        clock;
  logic        clear;
  logic [31:0] req;
  logic        done;
  logic        grant_valid;
  logic [31:0] grant_onehot;
  logic [4:0]  grant_code;
  logic        busy;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_phase;
  int m_ptr;
  int m_owner;
  int m_held;
  bit m_timeout;

  bus_arbiter #(.N_SRC(32), .CODE_W(5), .MAX_HOLD(MAX_HOLD)) dut (
    .clock        (clock),
    .clear        (clear),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot),
    .grant_code   (grant_code),
    .busy         (busy),
    .timeout      (timeout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pick(input logic [31:0] r);
    for (int i = 0; i < 32; i++) begin
      int j;
`ifdef BUS_ARB_FIXED_PRIO_EN
      j = i;
`else
      j = (m_ptr + i) % 32;
`endif
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_ptr     = 0;
    m_owner   = 0;
    m_held    = 0;
    m_timeout = 1'b0;
  endtask

  task automatic model_start(input int w);
    m_phase = PH_GRANT;
    m_owner = w;
    m_held  = 1;
`ifndef BUS_ARB_FIXED_PRIO_EN
    m_ptr   = (w + 1) % 32;
`endif
  endtask

  task automatic model_step(input logic [31:0] r, input logic d);
    int w;
    m_timeout = 1'b0;
    case (m_phase)
      PH_IDLE: begin
        w = pick(r);
        if (w >= 0) model_start(w);
      end
      PH_GRANT: begin
        if (d || !r[m_owner]) m_phase = PH_GAP;
        else if (m_held == MAX_HOLD) begin
          m_phase   = PH_GAP;
          m_timeout = 1'b1;
        end else m_held++;
      end
      default: begin
        w = pick(r);
        if (w >= 0) model_start(w);
        else m_phase = PH_IDLE;
      end
    endcase
  endtask

  // Advance one clock; model consumes the same inputs the DUT sampled, outputs are read 1ns later.
  task automatic tick();
    @(posedge clock);
    model_step(req, done);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    done  = 1'b0;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    req  = '0;
    done = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    clear = 1'b1;
    req   = 32'hFFFF_FFFF;
    done  = 1'b0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    n_checks++;
    if ({grant_valid, grant_onehot, grant_code, busy, timeout} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b oh=%h code=%0d busy=%b to=%b, expected all zero",
               grant_valid, grant_onehot, grant_code, busy, timeout);
    end
    req   = '0;
    clear = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || grant_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b, expected 0 0", busy, grant_valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    req = 32'h0000_0010;
    tick();
    n_checks++;
    if (grant_valid !== 1'b1 || grant_code !== 5'd4 || grant_onehot !== 32'h10) begin
      n_errors++;
      $display("FAIL first_grant: got v=%b code=%0d oh=%h, expected 1 4 00000010",
               grant_valid, grant_code, grant_onehot);
    end
    tick();
    #2;
    clear = 1'b1;
    #1;
    n_checks++;
    if (grant_onehot !== 32'h0 || grant_valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL async_clear: got oh=%h v=%b to=%b busy=%b, expected all zero before edge",
               grant_onehot, grant_valid, timeout, busy);
    end
    @(posedge clock);
    #1;
    clear = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if (grant_valid !== 1'b1 || grant_code !== 5'd4 || grant_onehot !== 32'h10) begin
      n_errors++;
      $display("FAIL regrant_after_clear: got v=%b code=%0d oh=%h, expected 1 4 00000010",
               grant_valid, grant_code, grant_onehot);
    end
    drain();
  endtask

  task automatic test_hold_timeout();
    req  = 32'h0000_0004;
    done = 1'b0;
    tick();
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        n_checks++;
        if (grant_valid !== 1'b1 || grant_code !== 5'd2 || timeout !== 1'b0) begin
          n_errors++;
          $display("FAIL hold_cycle rep=%0d c=%0d: got v=%b code=%0d to=%b, expected 1 2 0",
                   rep, c, grant_valid, grant_code, timeout);
        end
        tick();
      end
      n_checks++;
      if (grant_valid !== 1'b0 || busy !== 1'b1 || timeout !== 1'b1 || grant_onehot !== 32'h0) begin
        n_errors++;
        $display("FAIL timeout_gap rep=%0d: got v=%b busy=%b to=%b oh=%h, expected 0 1 1 0",
                 rep, grant_valid, busy, timeout, grant_onehot);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_rotation();
    int rot_exp [6];
`ifdef BUS_ARB_FIXED_PRIO_EN
    rot_exp = '{0, 0, 0, 0, 0, 0};
`else
    rot_exp = '{0, 1, 31, 0, 1, 31};
`endif
    do_reset();
    req = 32'h8000_0003;
    for (int g = 0; g < 6; g++) begin
      tick();
      n_checks++;
      if (grant_valid !== 1'b1 || grant_code !== 5'(rot_exp[g]) ||
          grant_onehot !== (32'h1 << rot_exp[g])) begin
        n_errors++;
        $display("FAIL rotation g=%0d: got v=%b code=%0d oh=%h, expected code %0d",
                 g, grant_valid, grant_code, grant_onehot, rot_exp[g]);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if (grant_valid !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0 || grant_onehot !== 32'h0) begin
        n_errors++;
        $display("FAIL rotation_gap g=%0d: got v=%b busy=%b to=%b oh=%h, expected 0 1 0 0",
                 g, grant_valid, busy, timeout, grant_onehot);
      end
    end
    drain();
  endtask

  task automatic test_wraparound();
    int first_exp;
`ifdef BUS_ARB_FIXED_PRIO_EN
    first_exp = 0;
`else
    first_exp = 31;
`endif
    do_reset();
    req = 32'h4000_0000;
    tick();
    n_checks++;
    if (grant_code !== 5'd30 || grant_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_setup: got code=%0d v=%b, expected 30 1", grant_code, grant_valid);
    end
    done = 1'b1;
    req  = '0;
    tick();
    done = 1'b0;
    req  = 32'h8000_0001;
    tick();
    n_checks++;
    if (grant_code !== 5'(first_exp) || grant_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_first: got code=%0d v=%b, expected %0d 1", grant_code, grant_valid, first_exp);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    n_checks++;
    if (grant_code !== 5'd0 || grant_valid !== 1'b1 || grant_onehot !== 32'h1) begin
      n_errors++;
      $display("FAIL wrap_second: got code=%0d v=%b oh=%h, expected 0 1 00000001",
               grant_code, grant_valid, grant_onehot);
    end
    drain();
  endtask

  task automatic test_done_and_expiry();
    do_reset();
    req = 32'h0000_0004;
    for (int c = 0; c < MAX_HOLD; c++) tick();
    n_checks++;
    if (grant_valid !== 1'b1 || grant_code !== 5'd2) begin
      n_errors++;
      $display("FAIL last_hold_cycle: got v=%b code=%0d, expected 1 2", grant_valid, grant_code);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (grant_valid !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL done_beats_expiry: got v=%b busy=%b to=%b, expected 0 1 0",
               grant_valid, busy, timeout);
    end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] e_onehot;
    logic [4:0]  e_code;
    logic        e_valid;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(3) == 0) begin
        req = '0;
        for (int b = 0; b < 3; b++)
          if ($urandom_range(3) != 0) req[$urandom_range(31)] = 1'b1;
      end
      done = ($urandom_range(4) == 0);
      tick();
      e_valid  = (m_phase == PH_GRANT);
      e_onehot = e_valid ? (32'h1 << m_owner) : 32'h0;
      e_code   = e_valid ? 5'(m_owner) : 5'd0;
      n_checks++;
      if (grant_valid !== e_valid || grant_onehot !== e_onehot || grant_code !== e_code ||
          busy !== (m_phase != PH_IDLE) || timeout !== m_timeout) begin
        n_errors++;
        $display("FAIL random cyc=%0d: got v=%b oh=%h code=%0d busy=%b to=%b, expected v=%b oh=%h code=%0d busy=%b to=%b",
                 cyc, grant_valid, grant_onehot, grant_code, busy, timeout,
                 e_valid, e_onehot, e_code, (m_phase != PH_IDLE), m_timeout);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_reset_mid_grant();
    test_hold_timeout();
    test_rotation();
    test_wraparound();
    test_done_and_expiry();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 32-source internal CPU bus.
- Takes bus-drive requests from up to 32 sources (R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C_sign_extended, ...).
- Grants exactly one source at a time and holds the grant for a bounded number of cycles.
- Produces the one-hot drive enables plus the 5-bit mux select that steers the bus multiplexer.

Parameters:
- N_SRC, 32, number of requesters; fixed at 32 to match the 5-bit bus select.
- CODE_W, 5, width of grant_code.
- MAX_HOLD, 4, maximum consecutive cycles one grant may last; legal range 1..15.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  asynchronous, active-high reset.
- req  in  32  per-source bus request; level-sensitive.
- done  in  1  current owner finished; releases the bus.
- grant_valid  out  1  a grant is active this cycle.
- grant_onehot  out  32  drive enable; exactly one bit high when grant_valid, else all zero.
- grant_code  out  5  index of granted source; 0 when grant_valid=0.
- busy  out  1  state is GRANT or GAP.
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Clock and reset: single clock domain. clear is asynchronous and active-high. While clear=1, all outputs are 0, state=IDLE, rr_ptr=0, hold_cnt=0.
- Reset mid-grant: clear drops grant_onehot to 0 immediately, without waiting for a clock edge. No timeout pulse is produced.
- Registered outputs: all outputs come from flops, with no combinational path from req to grant.
- States: IDLE, GRANT, GAP.
- IDLE:
  - Outputs are zero.
  - If any req bit is high, latch the winner and go to GRANT.
  - Latency: req asserted at edge N gives grant_valid=1 after edge N+1.
- Winner selection (round-robin):
  - Search upward from rr_ptr, wrapping 31->0; the first set req bit wins.
  - On every new grant to index k: rr_ptr <= (k+1) mod 32, hold_cnt <= 0.
- GRANT: grant_onehot[k]=1, grant_code=k, grant_valid=1, busy=1. Evaluated every cycle in this priority order:
  1. done=1 -> GAP.
  2. Else req[k]=0 -> GAP.
  3. Else hold_cnt==MAX_HOLD-1 -> GAP, with timeout=1 during the first GAP cycle.
  4. Else hold_cnt increments and the state stays GRANT.
- Grant length: one grant lasts between 1 and MAX_HOLD cycles.
- Simultaneous events: done and expiry in the same cycle count as done, so there is no timeout pulse.
- GAP:
  - One dead cycle with grant_valid=0, grant_onehot=0 and busy=1, preventing drive overlap on the bus.
  - Arbitration runs during GAP. If any req is high, go to GRANT with the new winner; otherwise go to IDLE.
  - Back-to-back grants are therefore separated by exactly one dead cycle.
- Single requester: a sole persistent requester is re-granted after each GAP, because rr_ptr wraps around to it.
- grant_code when idle: 0, never X. grant_code always equals the index of the set bit in grant_onehot.
- Requests arriving during GRANT are ignored until the next arbitration point. There is no preemption.
- hold_cnt width: 4 bits.

Optional Feature:
- Macro: BUS_ARB_FIXED_PRIO_EN.
- Defined: winner is always the lowest-index set req bit, so index 0 has highest priority. rr_ptr is not implemented and stays 0. Timeout and GAP rules are unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset mid-grant:
  - Stimulus: req=32'h0000_0010, then clear asserted asynchronously two cycles after the grant.
  - Required: grant_onehot goes to 0 before the next edge. After release, a fresh grant to 4 appears one cycle later.
- Hold and timeout:
  - Stimulus: req=32'h0000_0004 held constant, done=0, MAX_HOLD=4.
  - Required: grant_code=2 for 4 cycles, then a GAP with timeout=1, then re-grant to 2. The pattern repeats.
- Round-robin rotation:
  - Stimulus: req=32'h8000_0003 constant, done pulsed on every grant's first cycle.
  - Required: grant sequence 0,1,31,0,1,31 with one dead cycle between each.
- Wrap-around:
  - Stimulus: rr_ptr driven to 31 via a grant to 30, then req=32'h8000_0001.
  - Required: next grant is 31, then 0.
- Simultaneous done and expiry:
  - Stimulus: done=1 on the cycle where hold_cnt=MAX_HOLD-1.
  - Required: GAP with timeout=0.
- Fixed-priority build:
  - Stimulus: BUS_ARB_FIXED_PRIO_EN defined, req=32'h8000_0003 constant, done pulsed on every grant.
  - Required: grants alternate 0,0,0, and sources 1 and 31 are never granted.
